// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: drives an external combinational 32-bit logical barrel shifter
// over one or two passes to build SLL, SRL, SRA, ROL and ROR behind valid/ready handshakes.
module shift_seq_ctrl #(
  parameter int unsigned DATA_W       = 32,
  parameter bit          ALLOW_ROTATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [DATA_W-1:0] req_amt,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [DATA_W-1:0] sh_inp,
  output logic              sh_dir,
  output logic [DATA_W-1:0] sh_amt,
  input  logic [DATA_W-1:0] sh_out
);

  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
  localparam logic [2:0] OpRol = 3'b011;
  localparam logic [2:0] OpRor = 3'b100;

  localparam logic [DATA_W-1:0] FullW   = DATA_W'(DATA_W);
  localparam logic [DATA_W-1:0] AllOnes = '1;

  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_amt;
  logic [DATA_W-1:0] r_r1;
  logic              r_illegal;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;

  logic              w_req_legal;
  logic              w_single_pass;
  logic [DATA_W-1:0] w_sra_n;
  logic [DATA_W-1:0] w_rot_n;
  logic [DATA_W-1:0] w_pass2_res;

  assign w_req_legal = (req_op == OpSll) || (req_op == OpSrl) || (req_op == OpSra) ||
                       (ALLOW_ROTATE && ((req_op == OpRol) || (req_op == OpRor)));

  assign w_single_pass = (r_op == OpSll) || (r_op == OpSrl);
  assign w_sra_n       = (r_amt > FullW) ? FullW : r_amt;
  assign w_rot_n       = {{(DATA_W-5){1'b0}}, r_amt[4:0]};

  // SRA fills vacated high bits with ones only for negative operands; rotates merge both halves.
  assign w_pass2_res = (r_op == OpSra) ? (r_data[DATA_W-1] ? (r_r1 | sh_out) : r_r1)
                                       : (r_r1 | sh_out);

  assign resp_valid = (r_state == StDone);
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    sh_inp       = '0;
    sh_dir       = 1'b0;
    sh_amt       = '0;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = StPass1;
      end
      StPass1: begin
        // Illegal ops idle here one cycle so their latency matches SLL/SRL.
        if (!r_illegal) begin
          case (r_op)
            OpSll: begin sh_inp = r_data; sh_dir = 1'b1; sh_amt = r_amt;   end
            OpSrl: begin sh_inp = r_data; sh_dir = 1'b0; sh_amt = r_amt;   end
            OpSra: begin sh_inp = r_data; sh_dir = 1'b0; sh_amt = w_sra_n; end
            OpRol: begin sh_inp = r_data; sh_dir = 1'b1; sh_amt = w_rot_n; end
            OpRor: begin sh_inp = r_data; sh_dir = 1'b0; sh_amt = w_rot_n; end
            default: ;
          endcase
        end
        w_state_next = (r_illegal || w_single_pass) ? StDone : StPass2;
      end
      StPass2: begin
        case (r_op)
          OpSra: begin sh_inp = AllOnes; sh_dir = 1'b1; sh_amt = FullW - w_sra_n; end
          OpRol: begin sh_inp = r_data;  sh_dir = 1'b0; sh_amt = FullW - w_rot_n; end
          OpRor: begin sh_inp = r_data;  sh_dir = 1'b1; sh_amt = FullW - w_rot_n; end
          default: ;
        endcase
        w_state_next = StDone;
      end
      StDone: begin
        if (resp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_op        <= '0;
      r_data      <= '0;
      r_amt       <= '0;
      r_r1        <= '0;
      r_illegal   <= 1'b0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_op      <= req_op;
            r_data    <= req_data;
            r_amt     <= req_amt;
            r_illegal <= !w_req_legal;
          end
        end
        StPass1: begin
          r_r1 <= sh_out;
          if (r_illegal) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
          end else if (w_single_pass) begin
            r_resp_data <= sh_out;
            r_resp_err  <= 1'b0;
          end
        end
        StPass2: begin
          r_resp_data <= w_pass2_res;
          r_resp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl; a behavioural barrel shifter closes the loop.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_data;
  logic [31:0] req_amt;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] sh_inp;
  logic        sh_dir;
  logic [31:0] sh_amt;
  logic [31:0] sh_out;

  logic        req_valid_nr;
  logic        req_ready_nr;
  logic        resp_valid_nr;
  logic [31:0] resp_data_nr;
  logic        resp_err_nr;
  logic [31:0] sh_inp_nr;
  logic        sh_dir_nr;
  logic [31:0] sh_amt_nr;
  logic [31:0] sh_out_nr;

  int errors = 0;
  int checks = 0;

  shift_seq_ctrl #(.DATA_W(32), .ALLOW_ROTATE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_amt(req_amt), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .sh_inp(sh_inp), .sh_dir(sh_dir),
    .sh_amt(sh_amt), .sh_out(sh_out)
  );

  shift_seq_ctrl #(.DATA_W(32), .ALLOW_ROTATE(1'b0)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_nr), .req_ready(req_ready_nr),
    .req_op(req_op), .req_data(req_data), .req_amt(req_amt), .resp_valid(resp_valid_nr),
    .resp_ready(resp_ready), .resp_data(resp_data_nr), .resp_err(resp_err_nr),
    .sh_inp(sh_inp_nr), .sh_dir(sh_dir_nr), .sh_amt(sh_amt_nr), .sh_out(sh_out_nr)
  );

  assign sh_out    = (sh_amt > 32'd31) ? 32'd0 :
                     (sh_dir ? (sh_inp << sh_amt[4:0]) : (sh_inp >> sh_amt[4:0]));
  assign sh_out_nr = (sh_amt_nr > 32'd31) ? 32'd0 :
                     (sh_dir_nr ? (sh_inp_nr << sh_amt_nr[4:0]) : (sh_inp_nr >> sh_amt_nr[4:0]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issues one request from IDLE, measures accept-to-resp_valid cycles (-1 on timeout),
  // captures the response and completes the handshake; returns at a falling edge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] d, input logic [31:0] a,
                       output logic [31:0] rd, output logic re, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = d; req_amt = a;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 20);
    if (!resp_valid) lat = -1;
    rd = resp_data;
    re = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_valid_nr = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_data = '0; req_amt = '0;
    #3;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    checks++; if ({sh_inp, sh_dir, sh_amt} !== 65'd0) begin errors++; $display("FAIL reset_sh: got %h/%b/%h want 0", sh_inp, sh_dir, sh_amt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp_valid: got %b want 0", resp_valid); end
  endtask

  task automatic test_sll_srl();
    logic [31:0] rd; logic re; int lat;
    do_op(3'b000, 32'h0000_00F1, 32'd4, rd, re, lat);
    checks++; if (rd !== 32'h0000_0F10) begin errors++; $display("FAIL sll4_data: got %h want 00000f10", rd); end
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL sll4_err: got %b want 0", re); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL sll4_latency: got %0d want 2", lat); end
    do_op(3'b000, 32'h0000_00F1, 32'd32, rd, re, lat);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sll32_data: got %h want 0", rd); end
    do_op(3'b001, 32'h8000_0000, 32'd31, rd, re, lat);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL srl31_data: got %h want 1", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL srl_latency: got %0d want 2", lat); end
  endtask

  task automatic test_sra();
    logic [31:0] rd; logic re; int lat;
    do_op(3'b010, 32'h8000_0000, 32'd4, rd, re, lat);
    checks++; if (rd !== 32'hF800_0000) begin errors++; $display("FAIL sra4_data: got %h want f8000000", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sra4_latency: got %0d want 3", lat); end
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL sra4_err: got %b want 0", re); end
    do_op(3'b010, 32'h8000_0000, 32'd40, rd, re, lat);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra40_neg: got %h want ffffffff", rd); end
    do_op(3'b010, 32'h7000_0000, 32'd40, rd, re, lat);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sra40_pos: got %h want 0", rd); end
    do_op(3'b010, 32'h8000_1234, 32'd0, rd, re, lat);
    checks++; if (rd !== 32'h8000_1234) begin errors++; $display("FAIL sra0_data: got %h want 80001234", rd); end
  endtask

  task automatic test_shifter_drive();
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b010; req_data = 32'h8000_0000; req_amt = 32'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if ({sh_inp, sh_dir, sh_amt} !== {32'h8000_0000, 1'b0, 32'd4}) begin
      errors++; $display("FAIL sra_pass1_drive: got %h/%b/%0d want 80000000/0/4", sh_inp, sh_dir, sh_amt); end
    @(negedge clk);
    checks++; if ({sh_inp, sh_dir, sh_amt} !== {32'hFFFF_FFFF, 1'b1, 32'd28}) begin
      errors++; $display("FAIL sra_pass2_drive: got %h/%b/%0d want ffffffff/1/28", sh_inp, sh_dir, sh_amt); end
    @(negedge clk);
    checks++; if ({sh_inp, sh_dir, sh_amt} !== 65'd0 || resp_valid !== 1'b1) begin
      errors++; $display("FAIL done_sh_idle: got %h/%b/%0d valid %b want 0/0/0 valid 1", sh_inp, sh_dir, sh_amt, resp_valid); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_rotate();
    logic [31:0] rd; logic re; int lat;
    do_op(3'b011, 32'h8000_0001, 32'd1, rd, re, lat);
    checks++; if (rd !== 32'h0000_0003) begin errors++; $display("FAIL rol1_data: got %h want 00000003", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rol1_latency: got %0d want 3", lat); end
    do_op(3'b100, 32'h8000_0001, 32'd1, rd, re, lat);
    checks++; if (rd !== 32'hC000_0000) begin errors++; $display("FAIL ror1_data: got %h want c0000000", rd); end
    do_op(3'b011, 32'h8000_0001, 32'd33, rd, re, lat);
    checks++; if (rd !== 32'h0000_0003) begin errors++; $display("FAIL rol33_data: got %h want 00000003", rd); end
    do_op(3'b100, 32'h1234_5678, 32'd0, rd, re, lat);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ror0_data: got %h want 12345678", rd); end
    do_op(3'b100, 32'h0000_00F0, 32'd8, rd, re, lat);
    checks++; if (rd !== 32'hF000_0000) begin errors++; $display("FAIL ror8_data: got %h want f0000000", rd); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b001; req_data = 32'h0000_00F0; req_amt = 32'd4;
    @(posedge clk);
    @(negedge clk);
    // Second request held by the requester while the first is in flight.
    req_op = 3'b000; req_data = 32'h0000_0001; req_amt = 32'd1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0000_000F || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: got valid %b data %h ready %b want 1 0000000f 0", i, resp_valid, resp_data, req_ready); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL after_handshake: got valid %b ready %b want 0 1", resp_valid, req_ready); end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 20);
    checks++; if (resp_data !== 32'h0000_0002 || lat !== 2) begin
      errors++; $display("FAIL second_req: got %h lat %0d want 00000002 lat 2", resp_data, lat); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic re; int lat;
    do_op(3'b111, 32'hDEAD_BEEF, 32'd3, rd, re, lat);
    checks++; if (rd !== 32'd0 || re !== 1'b1) begin errors++; $display("FAIL op111: got %h err %b want 0 err 1", rd, re); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL op111_latency: got %0d want 2", lat); end
    do_op(3'b101, 32'hDEAD_BEEF, 32'd3, rd, re, lat);
    checks++; if (rd !== 32'd0 || re !== 1'b1) begin errors++; $display("FAIL op101: got %h err %b want 0 err 1", rd, re); end
    do_op(3'b000, 32'h0000_0001, 32'd1, rd, re, lat);
    checks++; if (rd !== 32'd2 || re !== 1'b0) begin errors++; $display("FAIL err_clears: got %h err %b want 2 err 0", rd, re); end
    @(negedge clk);
    req_valid_nr = 1'b1; req_op = 3'b011; req_data = 32'h8000_0001; req_amt = 32'd1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid_nr = 1'b0;
      lat++;
      checks++; if ({sh_inp_nr, sh_dir_nr, sh_amt_nr} !== 65'd0) begin
        errors++; $display("FAIL norot_sh_idle: got %h/%b/%0d want 0", sh_inp_nr, sh_dir_nr, sh_amt_nr); end
    end while (!resp_valid_nr && lat < 20);
    checks++; if (resp_data_nr !== 32'd0 || resp_err_nr !== 1'b1 || lat !== 2) begin
      errors++; $display("FAIL norot_rol: got %h err %b lat %0d want 0 err 1 lat 2", resp_data_nr, resp_err_nr, lat); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic re; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b100; req_data = 32'h8000_0001; req_amt = 32'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (sh_dir !== 1'b1 || sh_amt !== 32'd31) begin
      errors++; $display("FAIL ror_in_pass2: got dir %b amt %0d want 1 31", sh_dir, sh_amt); end
    rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || {sh_inp, sh_dir, sh_amt} !== 65'd0) begin
      errors++; $display("FAIL midop_reset: got valid %b sh %h/%b/%0d want 0", resp_valid, sh_inp, sh_dir, sh_amt); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== 32'd0) begin
        errors++; $display("FAIL no_stale[%0d]: got valid %b ready %b data %h want 0 1 0", i, resp_valid, req_ready, resp_data); end
    end
    do_op(3'b100, 32'h8000_0001, 32'd1, rd, re, lat);
    checks++; if (rd !== 32'hC000_0000 || lat !== 3) begin
      errors++; $display("FAIL ror_after_reset: got %h lat %0d want c0000000 lat 3", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_sll_srl();
    test_sra();
    test_shifter_drive();
    test_rotate();
    test_back_to_back();
    test_illegal();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
